unary_hls_deadlock_reporter: RTL
================================

Name: unary_hls_deadlock_reporter

Overview:
- Consumer end of the per-instance deadlock monitor `block` flags.
- Samples NUM_MON monitor outputs and requires a block condition to persist PERSIST consecutive cycles before declaring deadlock; filters transient stalls.
- Emits one report (blocked-monitor mask + timestamp) over a valid/ready handshake and raises a sticky `deadlock` flag.
- Sits beside the kernel top; feeds the host-visible status/debug path.

Parameters:
- NUM_MON, 4, number of monitor `block` inputs (>=1).
- PERSIST, 1024, consecutive blocked cycles required before reporting (>=1); internal counter width is $clog2(PERSIST+1).
- TS_W, 32, timestamp width.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- block_sigs  input  NUM_MON  monitor `block` outputs, bit i = monitor i.
- clear  input  1  single-cycle pulse; abandons/acknowledges deadlock and re-arms.
- report_valid  output  1  report available.
- report_ready  input  1  consumer accepts report.
- report_mask  output  NUM_MON  OR of every monitor seen blocked during the qualifying window.
- report_ts  output  TS_W  timestamp value at the REPORT entry edge.
- deadlock  output  1  sticky deadlock indication.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; sample reg s_q=0; cnt=0; mask=0; ts=0; report_valid=0; report_mask=0; report_ts=0; deadlock=0.
- Input stage: s_q <= block_sigs every edge; all decisions use s_q (1-cycle input latency).
- Timestamp: ts increments every edge from reset; saturates at all-ones, no wrap.
- FSM:
  - IDLE: if s_q!=0 -> WATCH, cnt<=1, mask<=s_q.
  - WATCH:
    - s_q==0 -> IDLE, cnt<=0, mask<=0 (one clear cycle breaks persistence).
    - Else if cnt==PERSIST -> REPORT; report_mask<=mask|s_q; report_ts<=ts; deadlock<=1.
    - Else cnt<=cnt+1, mask<=mask|s_q.
    - A change in which bits are set does not reset cnt; only all-zero does.
  - REPORT:
    - report_valid=1; report_mask/report_ts held stable until handshake (valid&ready on an edge).
    - On handshake -> HALT; report_valid<=0.
    - Changes on block_sigs are ignored.
  - HALT: report_valid=0; deadlock=1; ignores block_sigs; leaves only on clear.
- Latency: block_sigs held from edge 0 -> report_valid and deadlock high after edge PERSIST+1.
- report_valid never drops without a handshake, except on clear or reset.
- clear (any state) -> IDLE next edge; cnt, mask, report_valid, report_mask, report_ts, deadlock <= 0; ts unaffected.
- clear in the same cycle as a handshake: clear wins the state transition; the consumer still counts the report as transferred.
- clear while block_sigs is still set: re-enters WATCH on the following edge and needs a fresh PERSIST window.
- Reset mid-report: report_valid drops asynchronously; the report is lost.

Optional Feature:
- Macro DEADLOCK_REPORTER_AUTO_REARM_EN.
- Defined: after a REPORT handshake the FSM goes to IDLE instead of HALT. `deadlock` stays sticky until clear. Further persistent blocks produce further reports, each with a fresh mask and timestamp.
- Undefined: HALT behaviour as above; exactly one report per clear/reset.

Test Plan:
- PERSIST=8, NUM_MON=4; block_sigs=4'b0010 held from edge 0, report_ready=1 -> report_valid and deadlock high after edge 9; report_mask=4'b0010; report_ts=9; HALT after handshake.
- block_sigs=4'b0001 for 5 cycles, 0 for 1 cycle, 4'b0001 for 5 cycles -> no report_valid, deadlock=0 throughout.
- block_sigs 4'b0001 for 4 cycles, then 4'b1000 held (never all-zero), report_ready=0 -> report after edge 9 with report_mask=4'b1001. Valid, mask and ts stay stable for 20 cycles until ready=1; single transfer.
- In HALT with block_sigs still 4'b1111, pulse clear -> deadlock=0 next edge; WATCH restarts; new report after 9 further edges, new report_ts (undefined macro) or repeated reports (macro defined, clear not pulsed).
- Drop reset_n mid-REPORT -> report_valid and deadlock 0 immediately, no clock needed; ts restarts from 0.
- Timestamp saturation (TS_W=4, PERSIST=20) -> report_ts=4'hF.

Source files
------------

// File: rtl/unary_hls_deadlock_reporter.sv
`default_nettype none
// ============================================================================
// Module   : unary_hls_deadlock_reporter
// Purpose  : Declares deadlock once any monitor block flag persists, and emits
//            one mask + timestamp report. DEADLOCK_REPORTER_AUTO_REARM_EN
//            re-arms after each report instead of halting.
// Revision : 1.0 - initial release
// ============================================================================
module unary_hls_deadlock_reporter #(
    parameter int NUM_MON = 4,
    parameter int PERSIST = 1024,
    parameter int TS_W    = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_MON-1:0] block_sigs,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [NUM_MON-1:0] report_mask,
    output logic [TS_W-1:0]    report_ts,
    output logic               deadlock
);

    localparam int                CNT_W       = $clog2(PERSIST + 1);
    localparam logic [CNT_W-1:0]  PERSIST_CNT = CNT_W'(PERSIST);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WATCH  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_MON-1:0] s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MON-1:0] mask_q, mask_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [NUM_MON-1:0] rmask_q, rmask_d;
    logic [TS_W-1:0]    rts_q, rts_d;
    logic               dl_q, dl_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            ts_q    <= '0;
            rmask_q <= '0;
            rts_q   <= '0;
            dl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            ts_q    <= ts_d;
            rmask_q <= rmask_d;
            rts_q   <= rts_d;
            dl_q    <= dl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = block_sigs;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        rmask_d = rmask_q;
        rts_d   = rts_q;
        dl_d    = dl_q;
        // Free-running timestamp that sticks at all-ones rather than wrapping
        ts_d    = (ts_q == '1) ? ts_q : ts_q + 1'b1;

        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            mask_d  = '0;
            rmask_d = '0;
            rts_d   = '0;
            dl_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_q != '0) begin
                        state_d = ST_WATCH;
                        cnt_d   = CNT_W'(1);
                        mask_d  = s_q;
                    end
                end
                ST_WATCH: begin
                    // Only an all-zero sample breaks the window; bit changes do not
                    if (s_q == '0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        mask_d  = '0;
                    end else if (cnt_q == PERSIST_CNT) begin
                        state_d = ST_REPORT;
                        rmask_d = mask_q | s_q;
                        rts_d   = ts_q;
                        dl_d    = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        mask_d  = mask_q | s_q;
                    end
                end
                ST_REPORT: begin
                    if (report_ready) begin
`ifdef DEADLOCK_REPORTER_AUTO_REARM_EN
                        state_d = ST_IDLE;
`else
                        state_d = ST_HALT;
`endif
                        cnt_d   = '0;
                        mask_d  = '0;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign report_valid = (state_q == ST_REPORT);
    assign report_mask  = rmask_q;
    assign report_ts    = rts_q;
    assign deadlock     = dl_q;

endmodule
`default_nettype wire
